// File: rtl/dmem_unloader.sv
`default_nettype none
// ============================================================================
// Module   : dmem_unloader
// Brief    : Reads the word count at data address 0, then streams words
//            1..count from the data memory out over a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module dmem_unloader #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] d_mem_addra,
    input  logic [DATA_W-1:0] d_mem_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_CNT  = 3'd1,
        S_RD_WORD = 3'd2,
        S_PRESENT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    // The count read takes one extra cycle over a word read.
    localparam logic [1:0] LAT_CNT  = 2'(RD_LAT);
    localparam logic [1:0] LAT_WORD = 2'(RD_LAT - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [1:0]          wait_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                done_q;
    logic                len_err_q;

    logic                ovf_d;
    logic [ADDR_W-1:0]   cnt_d;

    // A count that does not fit the address space is clamped to the top address.
    always_comb begin
        ovf_d = |d_mem_out[DATA_W-1:ADDR_W];
        cnt_d = ovf_d ? {ADDR_W{1'b1}} : d_mem_out[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        wait_q    <= '0;
                        state_q   <= S_RD_CNT;
                    end
                end
                S_RD_CNT: begin
                    if (wait_q == LAT_CNT) begin
                        cnt_q <= cnt_d;
                        if (ovf_d) begin
                            len_err_q <= 1'b1;
                        end
                        if (cnt_d == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= ADDR_W'(1);
                            addr_q  <= ADDR_W'(1);
                            wait_q  <= '0;
                            state_q <= S_RD_WORD;
                        end
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_RD_WORD: begin
                    if (wait_q == LAT_WORD) begin
                        data_q  <= d_mem_out;
                        valid_q <= 1'b1;
                        last_q  <= (idx_q == cnt_q);
                        state_q <= S_PRESENT;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            addr_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            addr_q  <= idx_q + ADDR_W'(1);
                            wait_q  <= '0;
                            state_q <= S_RD_WORD;
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign d_mem_addra = addr_q;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign len_err     = len_err_q;

endmodule
`default_nettype wire
